seven_seg_capture: RTL

- Receive side of the seven-segment display interface: samples the multiplexed, active-low anode/segment bus that drives a DIGITS-digit display.
- Waits for each digit's pattern to be stable, then decodes it back to a 4-bit hex value.
- Assembles a full frame and pulses frame_valid once every digit has been captured.
- Used for display loopback self-test and for snooping display buses from external boards.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_glyph_decode.sv | 21 ++
 rtl/seven_seg_capture.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, glyph table and FSM state type for seven_seg_capture
package seg_pkg;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high segment patterns g..a, indexed by hex value
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} cap_state_t;
endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - maps an active-high 7-segment pattern back to its hex value
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] value_o,
  output logic       legal_o
);

  always_comb begin
    value_o = '0;
    legal_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == GLYPH[i]) begin
        value_o = 4'(i);
        legal_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - samples a multiplexed active-low 7-seg bus and rebuilds the frame
module seven_seg_capture
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [7:0]            seg_n,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     capture_mask
);

  localparam logic [7:0] CNT_DONE = 8'(STABLE_CYCLES - 1);

  logic [DIGITS-1:0]   an_meta_q, an_sync_q, an_prev_q;
  logic [7:0]          seg_meta_q, seg_sync_q, seg_prev_q;
  logic [7:0]          cnt_q, cnt_d;
  cap_state_t          state_q, state_d;
  logic [4*DIGITS-1:0] sh_hex_q, sh_hex_d, hex_q, hex_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, dp_q, dp_d;
  logic [DIGITS-1:0]   sh_err_q, sh_err_d, err_q, err_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                fv_q;

  logic [DIGITS-1:0] an_act;
  logic              sel_ok, changed, capture, complete;
  logic [3:0]        glyph_value;
  logic              glyph_legal;

  assign an_act   = ~an_sync_q;
  assign sel_ok   = $onehot(an_act);
  assign changed  = {an_sync_q, seg_sync_q} != {an_prev_q, seg_prev_q};
  assign complete = &mask_q;

  seg_glyph_decode u_decode (
    .pattern_i (~seg_sync_q[SEG_G:SEG_A]),
    .value_o   (glyph_value),
    .legal_o   (glyph_legal)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (changed || !sel_ok) begin
      cnt_d = '0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Capture fires on the sample that completes the run, so edge-to-capture is 2 + STABLE_CYCLES
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_ok) state_d = SETTLE;
      end
      SETTLE: begin
        if (!sel_ok) begin
          state_d = IDLE;
        end else if (cnt_d >= CNT_DONE) begin
          state_d = HELD;
          capture = 1'b1;
        end
      end
      HELD: begin
        if (changed) state_d = sel_ok ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sh_hex_d = sh_hex_q;
    sh_dp_d  = sh_dp_q;
    sh_err_d = sh_err_q;
    mask_d   = complete ? '0 : mask_q;
    hex_d    = hex_q;
    dp_d     = dp_q;
    err_d    = err_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (capture && an_act[k]) begin
        sh_hex_d[4*k +: 4] = glyph_legal ? glyph_value : 4'h0;
        sh_err_d[k]        = ~glyph_legal;
        sh_dp_d[k]         = ~seg_sync_q[SEG_DP];
        mask_d[k]          = 1'b1;
      end
    end
    if (complete) begin
      hex_d = sh_hex_q;
      dp_d  = sh_dp_q;
      err_d = sh_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_meta_q  <= '0;
      an_sync_q  <= '0;
      an_prev_q  <= '0;
      seg_meta_q <= '0;
      seg_sync_q <= '0;
      seg_prev_q <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      sh_hex_q   <= '0;
      sh_dp_q    <= '0;
      sh_err_q   <= '0;
      mask_q     <= '0;
      hex_q      <= '0;
      dp_q       <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
    end else begin
      an_meta_q  <= an_n;
      an_sync_q  <= an_meta_q;
      an_prev_q  <= an_sync_q;
      seg_meta_q <= seg_n;
      seg_sync_q <= seg_meta_q;
      seg_prev_q <= seg_sync_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      sh_hex_q   <= sh_hex_d;
      sh_dp_q    <= sh_dp_d;
      sh_err_q   <= sh_err_d;
      mask_q     <= mask_d;
      hex_q      <= hex_d;
      dp_q       <= dp_d;
      err_q      <= err_d;
      fv_q       <= complete;
    end
  end

  assign hex_out      = hex_q;
  assign dp_out       = dp_q;
  assign digit_err    = err_q;
  assign frame_valid  = fv_q;
  assign capture_mask = mask_q;

endmodule
